// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: default width,
// op encodings and the sequencing FSM state encoding.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the datapath and the mult/div unit.
// master: start, op, in_a, in_b out; busy, done, div_by_zero, hi, lo in.
interface mult_div_unit_if
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) ();

    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, in_a, in_b,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, in_a, in_b,
        output busy, done, div_by_zero, hi, lo
    );

endinterface

// File: rtl/mult_div_unit_sign_fix.sv
// Conditional two's-complement negation, either of the full 2*WIDTH
// value (wide=1, flag neg_lo) or of each WIDTH half independently.
// Ports: val in, wide/neg_hi/neg_lo controls, res out.
module mdu_sign_fix
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic [2*WIDTH-1:0] val,
    input  logic               wide,
    input  logic               neg_hi,
    input  logic               neg_lo,
    output logic [2*WIDTH-1:0] res
);

    logic [WIDTH-1:0] half_hi;
    logic [WIDTH-1:0] half_lo;

    assign half_hi = val[2*WIDTH-1:WIDTH];
    assign half_lo = val[WIDTH-1:0];

    always_comb begin
        res = val;
        if (wide) begin
            if (neg_lo) begin
                res = -val;
            end
        end else begin
            if (neg_hi) begin
                res[2*WIDTH-1:WIDTH] = -half_hi;
            end
            if (neg_lo) begin
                res[WIDTH-1:0] = -half_lo;
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO.
// Ports: clock, reset (sync, active-low), bus (slave side of the bundle).
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic            clock,
    input  logic            reset,
    mult_div_unit_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);

    state_t             state;
    logic [CW-1:0]      counter;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               is_div;
    logic               sign_a;
    logic               sign_b;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

    logic               op_signed;
    logic               op_div;
    logic [2*WIDTH-1:0] mag;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    // MULT and DIV are the only signed ops: op[2]=0 and op[0]=0.
    assign op_signed = ~bus.op[2] & ~bus.op[0];
    assign op_div    = bus.op[1];

    mdu_sign_fix #(.WIDTH(WIDTH)) u_mag (
        .val    ({bus.in_b, bus.in_a}),
        .wide   (1'b0),
        .neg_hi (op_signed & bus.in_b[WIDTH-1]),
        .neg_lo (op_signed & bus.in_a[WIDTH-1]),
        .res    (mag)
    );

    assign mag_b = mag[2*WIDTH-1:WIDTH];
    assign mag_a = mag[WIDTH-1:0];

    // Multiply: multiplier sits in acc low half and shifts out, partial
    // product accumulates into the high half with its carry.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                    + {1'b0, (acc[0] ? opnd : '0)};
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}. A set top bit of the
    // WIDTH+1 difference means the trial subtract went negative.
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;

    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd};
    assign div_next  = div_diff[WIDTH]
                     ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                     : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    // Remainder follows the dividend sign; quotient/product follow a^b.
    logic [2*WIDTH-1:0] fix_res;

    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix (
        .val    (acc),
        .wide   (~is_div),
        .neg_hi (is_div ? sign_a : (sign_a ^ sign_b)),
        .neg_lo (sign_a ^ sign_b),
        .res    (fix_res)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= ST_IDLE;
            counter <= '0;
            acc     <= '0;
            opnd    <= '0;
            is_div  <= 1'b0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        if (bus.op == OP_MTHI) begin
                            hi_q <= bus.in_a;
                        end else if (bus.op == OP_MTLO) begin
                            lo_q <= bus.in_a;
                        end else if (!bus.op[2]) begin
                            busy_q  <= 1'b1;
                            dbz_q   <= 1'b0;
                            is_div  <= op_div;
                            sign_a  <= op_signed & bus.in_a[WIDTH-1];
                            sign_b  <= op_signed & bus.in_b[WIDTH-1];
                            counter <= CW'(WIDTH - 1);
                            if (op_div) begin
                                acc  <= {{WIDTH{1'b0}}, mag_a};
                                opnd <= mag_b;
                            end else begin
                                acc  <= {{WIDTH{1'b0}}, mag_b};
                                opnd <= mag_a;
                            end
                            if (op_div && bus.in_b == '0) begin
                                dbz_q <= 1'b1;
                                state <= ST_DONE;
                            end else begin
                                state <= ST_RUN;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    acc     <= is_div ? div_next : mul_next;
                    counter <= counter - 1'b1;
                    if (counter == '0) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    hi_q  <= fix_res[2*WIDTH-1:WIDTH];
                    lo_q  <= fix_res[WIDTH-1:0];
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: products, quotients, signs,
// divide-by-zero, MTHI/MTLO, ignored starts and mid-op reset.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic launch(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = op;
        bus.in_a  = a;
        bus.in_b  = b;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.in_a  = 32'hDEAD_BEEF;
        bus.in_b  = 32'h0BAD_F00D;
    endtask

    // Cycles counted from the sampling edge; -1 means done never came.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clock);
            #1;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy got %b want 0", bus.busy);
        end
        vectors++;
        if (bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_done got %b want 0", bus.done);
        end
        vectors++;
        if (bus.div_by_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_dbz got %b want 0", bus.div_by_zero);
        end
        vectors++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_hilo got %h/%h want 0/0", bus.hi, bus.lo);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_multu;
        int lat;
        launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL multu_busy got %b want 1", bus.busy);
        end
        wait_done(lat);
        vectors++;
        if (lat !== 34) begin
            miscompares++;
            $display("FAIL multu_latency got %0d want 34", lat);
        end
        vectors++;
        if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) begin
            miscompares++;
            $display("FAIL multu_result got %h/%h want fffffffe/00000001",
                     bus.hi, bus.lo);
        end
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL multu_busy_done got %b want 0", bus.busy);
        end
        @(posedge clock);
        #1;
        vectors++;
        if (bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse got %b want 0", bus.done);
        end
    endtask

    task automatic test_mult_signed;
        int lat;
        launch(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_done(lat);
        vectors++;
        if (lat !== 34 || bus.hi !== 32'hFFFF_FFFF
            || bus.lo !== 32'hFFFF_FFEB) begin
            miscompares++;
            $display("FAIL mult_neg got lat %0d %h/%h want 34 ffffffff/ffffffeb",
                     lat, bus.hi, bus.lo);
        end
        launch(OP_MULT, 32'hFFFF_FFF6, 32'hFFFF_FFFB);
        wait_done(lat);
        vectors++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'd50) begin
            miscompares++;
            $display("FAIL mult_negneg got %h/%h want 00000000/00000032",
                     bus.hi, bus.lo);
        end
    endtask

    task automatic test_div;
        int lat;
        launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat);
        vectors++;
        if (lat !== 34 || bus.lo !== 32'hFFFF_FFFD
            || bus.hi !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL div_signed got lat %0d hi %h lo %h want 34 ffffffff fffffffd",
                     lat, bus.hi, bus.lo);
        end
        launch(OP_DIVU, 32'd100, 32'd7);
        wait_done(lat);
        vectors++;
        if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
            miscompares++;
            $display("FAIL divu got hi %h lo %h want 2 e", bus.hi, bus.lo);
        end
        launch(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        wait_done(lat);
        vectors++;
        if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'd1) begin
            miscompares++;
            $display("FAIL div_negdivisor got hi %h lo %h want 1 fffffffd",
                     bus.hi, bus.lo);
        end
    endtask

    task automatic test_div_overflow;
        int lat;
        launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat);
        vectors++;
        if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'h0) begin
            miscompares++;
            $display("FAIL div_overflow got hi %h lo %h want 0 80000000",
                     bus.hi, bus.lo);
        end
        vectors++;
        if (bus.div_by_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL div_overflow_dbz got %b want 0", bus.div_by_zero);
        end
    endtask

    task automatic test_div_zero;
        int lat;
        launch(OP_MTHI, 32'h11, 32'h0);
        launch(OP_MTLO, 32'h22, 32'h0);
        launch(3'b110, 32'h99, 32'h99);
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL mt_no_busy got busy %b done %b want 0 0",
                     bus.busy, bus.done);
        end
        vectors++;
        if (bus.hi !== 32'h11 || bus.lo !== 32'h22) begin
            miscompares++;
            $display("FAIL mthi_mtlo got %h/%h want 11/22", bus.hi, bus.lo);
        end
        launch(OP_DIVU, 32'd55, 32'd0);
        wait_done(lat);
        vectors++;
        if (lat !== 1) begin
            miscompares++;
            $display("FAIL dbz_latency got %0d want 1", lat);
        end
        vectors++;
        if (bus.div_by_zero !== 1'b1) begin
            miscompares++;
            $display("FAIL dbz_flag got %b want 1", bus.div_by_zero);
        end
        vectors++;
        if (bus.hi !== 32'h11 || bus.lo !== 32'h22) begin
            miscompares++;
            $display("FAIL dbz_hilo got %h/%h want 11/22", bus.hi, bus.lo);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        launch(OP_MULTU, 32'd6, 32'd7);
        vectors++;
        if (bus.div_by_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL dbz_clear got %b want 0", bus.div_by_zero);
        end
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clock);
            #1;
            if (bus.done) begin
                lat = n;
                break;
            end
            bus.start = (n == 5 || n == 20 || n == 32 || n == 33);
            bus.op    = OP_DIVU;
            bus.in_a  = 32'd1000;
            bus.in_b  = 32'd3;
        end
        bus.start = 1'b0;
        vectors++;
        if (lat !== 34 || bus.hi !== 32'h0 || bus.lo !== 32'd42) begin
            miscompares++;
            $display("FAIL ignore_start got lat %0d %h/%h want 34 0/2a",
                     lat, bus.hi, bus.lo);
        end
        @(posedge clock);
        #1;
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_start_idle got busy %b want 0", bus.busy);
        end
    endtask

    task automatic test_reset_mid;
        launch(OP_MULT, 32'd5, 32'd6);
        repeat (10) @(posedge clock);
        #1;
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_busy got %b want 1", bus.busy);
        end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        vectors++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_reset got busy %b %h/%h want 0 0/0",
                     bus.busy, bus.hi, bus.lo);
        end
        for (int n = 0; n < 40; n++) begin
            @(posedge clock);
            #1;
            vectors++;
            if (bus.done !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_abandon got done %b at %0d want 0",
                         bus.done, n);
                break;
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        bus.start   = 1'b0;
        bus.op      = 3'b000;
        bus.in_a    = '0;
        bus.in_b    = '0;
        test_reset();
        test_multu();
        test_mult_signed();
        test_div();
        test_div_overflow();
        test_div_zero();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
